spatz_bank_req_adapter: RTL and testbench
=========================================

Name: spatz_bank_req_adapter

Overview:
- Initiator-side adapter that drives one cache-side bank port of the hybrid cache/SPM SRAM wrapper.
- That port is a per-bank req/we/addr/wdata/be bundle with a same-cycle grant, and read data returns exactly Latency cycles after grant, with no backpressure.
- This block converts an upstream valid/ready request stream and a valid/ready response stream onto that port.
- It tracks in-flight reads, captures read data at the fixed return slot, buffers it in a response FIFO, and uses credits so no response is ever dropped.

Parameters:
- DataWidth, 32, data bits per word.
- ByteWidth, 8, bits per byte-enable lane; be width = DataWidth/ByteWidth.
- AddrWidth, 10, bank word-address width.
- Latency, 1, bank read latency in cycles (>= 1).
- RspDepth, 2, response FIFO entries (>= 1); full read throughput requires RspDepth >= Latency+1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request accepted this cycle.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AddrWidth  word address.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  DataWidth/ByteWidth  byte enables.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  downstream accepts response.
- rsp_rdata_o  out  DataWidth  read data.
- bank_req_o  out  1  bank request.
- bank_we_o  out  1  bank write enable.
- bank_addr_o  out  AddrWidth  bank address.
- bank_wdata_o  out  DataWidth  bank write data.
- bank_be_o  out  DataWidth/ByteWidth  bank byte enables.
- bank_gnt_i  in  1  same-cycle grant from bank (low when SPM has priority).
- bank_rdata_i  in  DataWidth  bank read data, valid Latency cycles after grant.
- idle_o  out  1  no reads in flight and FIFO empty.

Behaviour:
- Reset (rst_i high, async):
  - FIFO, credit counter and in-flight shift register cleared; all in-flight reads are discarded.
  - rsp_valid_o=0, rsp_rdata_o=0, idle_o=1.
  - req_ready_o=0 and bank_req_o=0 are forced combinationally while rst_i is high.
- Credit counter cnt (width clog2(RspDepth+1)) = in-flight reads + FIFO occupancy.
  - Read accept increments; rsp handshake (rsp_valid_o & rsp_ready_i) decrements.
  - Both in the same cycle: cnt unchanged.
  - cnt never exceeds RspDepth.
- rsp_hs denotes the response handshake rsp_valid_o & rsp_ready_i.
- credit_ok = (cnt < RspDepth) | rsp_hs. This is a combinational path from rsp_ready_i to req_ready_o and is intentional.
- bank_req_o = req_valid_i & (req_we_i | credit_ok). bank_we/addr/wdata/be pass req_* through combinationally.
- req_ready_o = bank_req_o & bank_gnt_i. An accept occurs in any cycle where req_valid_i & req_ready_o.
- Upstream rule: req_* are held stable while req_valid_i & ~req_ready_o. A denied grant consumes no credit and leaves no state change.
- Writes: no response, no credit, no FIFO entry; subject only to bank_gnt_i.
- Read accepted in cycle T:
  - A 1 is shifted into a Latency-deep valid shift register.
  - In cycle T+Latency, bank_rdata_i is pushed into the FIFO.
  - The entry is visible as rsp_valid_o from cycle T+Latency+1 (registered FIFO output, no bypass).
- FIFO:
  - In-order, registered outputs; rsp_rdata_o holds stable while rsp_valid_o & ~rsp_ready_i.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty (empty: push only, pop not possible).
  - Read and write pointers wrap modulo RspDepth.
  - Overflow is impossible by credit construction; a push while full is an assertion failure.
- Ordering: responses are returned in read-accept order.
- bank_rdata_i outside a capture slot is ignored.
- idle_o = (cnt == 0), registered-equivalent (derived from the cnt register).
- Throughput: with rsp_ready_i=1 and RspDepth >= Latency+1, one read per cycle is sustained.
- Mid-operation reset: in-flight data returning after reset release is ignored, because the shift register was cleared.

Test Plan:
1. Latency=1, RspDepth=2; read addr 0x005 with gnt=1 in cycle 0; bank_rdata_i=0xDEADBEEF in cycle 1 -> rsp_valid_o=1 with rsp_rdata_o=0xDEADBEEF in cycle 2; idle_o=0 in cycles 1-2, 1 in cycle 3 after the handshake.
2. Four back-to-back reads 0x10-0x13, rsp_ready_i=1, gnt=1, bank returns 0xA0-0xA3 -> req_ready_o=1 every cycle; responses 0xA0, 0xA1, 0xA2, 0xA3 in cycles 2-5.
3. rsp_ready_i=0, continuous reads -> exactly 2 accepted, then bank_req_o=0 and req_ready_o=0. A write issued next is accepted. Raising rsp_ready_i -> responses drain in order and reads resume in the same cycle as the first pop.
4. Read pending with bank_gnt_i=0 for 3 cycles -> req_ready_o=0 and cnt unchanged; gnt=1 in cycle 3 -> single accept, exactly one response.
5. Read granted in cycle 0, rst_i pulsed in cycle 1, bank drives 0x1234 in cycle 1 -> rsp_valid_o=0 and idle_o=1 after reset; no response ever appears.
6. Latency=3, RspDepth=4, 8 consecutive reads with rsp_ready_i=1 -> zero stall cycles; first response in cycle 4; 8 in-order responses.

Source files
------------

// File: rtl/spatz_bank_req_adapter_if.sv
// Bundle for the upstream request/response streams and the downstream
// SRAM bank port of spatz_bank_req_adapter.
//
// Handshake semantics: a request transfers in a cycle where req_valid_i and
// req_ready_o are both high; a response transfers in a cycle where
// rsp_valid_o and rsp_ready_i are both high. While valid is high and ready is
// low, the producer holds valid and the payload stable. The bank port has no
// ready of its own: bank_gnt_i is a same-cycle grant for bank_req_o, and read
// data comes back a fixed number of cycles after the grant with no stall.
interface spatz_bank_req_adapter_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned AddrWidth = 10
);
    localparam int unsigned BeWidth = DataWidth / ByteWidth;

    // Upstream request stream
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [BeWidth-1:0]   req_be_i;
    // Upstream response stream
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;
    // Bank port
    logic                 bank_req_o;
    logic                 bank_we_o;
    logic [AddrWidth-1:0] bank_addr_o;
    logic [DataWidth-1:0] bank_wdata_o;
    logic [BeWidth-1:0]   bank_be_o;
    logic                 bank_gnt_i;
    logic [DataWidth-1:0] bank_rdata_i;
    // Status
    logic                 idle_o;

    // Adapter side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o,
        input  rsp_ready_i,
        output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
        input  bank_gnt_i, bank_rdata_i,
        output idle_o
    );

    // Initiator / bank environment side
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o,
        output rsp_ready_i,
        input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
        output bank_gnt_i, bank_rdata_i,
        input  idle_o
    );
endinterface

// File: rtl/spatz_bank_req_adapter.sv
// Initiator-side adapter for one cache-side SRAM bank port. Requests pass
// straight through to the bank; reads are tracked in a Latency-deep valid
// shift register, captured at their fixed return slot into an in-order
// response FIFO, and throttled by credits so the FIFO can never overflow.
module spatz_bank_req_adapter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 2
) (
    input logic                    clk_i,
    input logic                    rst_i,
    spatz_bank_req_adapter_if.slave bus
);
    localparam int unsigned BeWidth  = DataWidth / ByteWidth;
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    localparam logic [CntWidth-1:0] DepthC  = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(RspDepth - 1);

    // Credits: reads in flight plus entries held in the FIFO
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    // FIFO occupancy and pointers
    logic [CntWidth-1:0]  fcnt_q, fcnt_d;
    logic [PtrWidth-1:0]  wptr_q, wptr_d;
    logic [PtrWidth-1:0]  rptr_q, rptr_d;
    // One bit per pipeline stage of the bank read latency
    logic [Latency-1:0]   inflight_q, inflight_d;
    logic [DataWidth-1:0] mem_q [RspDepth];

    logic                 rsp_valid;
    logic                 rsp_hs;
    logic                 credit_ok;
    logic                 bank_req;
    logic                 read_acc;
    logic                 push;
    logic                 pop;
    logic [AddrWidth-1:0] addr_w;
    logic [BeWidth-1:0]   be_w;

    // Request path: writes need only the grant, reads also need a credit.
    // A response popped this cycle frees its credit for a read this cycle.
    assign rsp_valid = (fcnt_q != '0);
    assign rsp_hs    = rsp_valid & bus.rsp_ready_i;
    assign credit_ok = (cnt_q < DepthC) | rsp_hs;
    assign bank_req  = ~rst_i & bus.req_valid_i & (bus.req_we_i | credit_ok);
    assign read_acc  = bank_req & bus.bank_gnt_i & ~bus.req_we_i;
    assign push      = inflight_q[Latency-1];
    assign pop       = rsp_hs;

    assign addr_w           = bus.req_addr_i;
    assign be_w             = bus.req_be_i;
    assign bus.bank_req_o   = bank_req;
    assign bus.bank_we_o    = bus.req_we_i;
    assign bus.bank_addr_o  = addr_w;
    assign bus.bank_wdata_o = bus.req_wdata_i;
    assign bus.bank_be_o    = be_w;
    assign bus.req_ready_o  = bank_req & bus.bank_gnt_i;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_rdata_o  = mem_q[rptr_q];
    assign bus.idle_o       = (cnt_q == '0);

    // Next-state for credits, FIFO bookkeeping and the in-flight shift register
    always_comb begin
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = '0;

        inflight_d[0] = read_acc;
        for (int i = 1; i < int'(Latency); i++) begin
            inflight_d[i] = inflight_q[i-1];
        end

        case ({read_acc, rsp_hs})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase

        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CntWidth'(1);
            2'b01:   fcnt_d = fcnt_q - CntWidth'(1);
            default: fcnt_d = fcnt_q;
        endcase

        if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
        if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
    end

    // State registers; reset discards every read still in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            fcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= '0;
            for (int i = 0; i < int'(RspDepth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            if (push) mem_q[wptr_q] <= bus.bank_rdata_i;
        end
    end

    // Credits guarantee a free slot for every returning read
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (fcnt_q == DepthC)));
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= DepthC);

endmodule

// File: tb/tb_spatz_bank_req_adapter.sv
// Directed bench for spatz_bank_req_adapter: one instance with Latency=1,
// RspDepth=2 and one with Latency=3, RspDepth=4. Inputs change 1ns after
// the rising edge, outputs are checked on the falling edge.
module tb_spatz_bank_req_adapter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    spatz_bank_req_adapter_if #(.DataWidth(32), .ByteWidth(8), .AddrWidth(10)) b1 ();
    spatz_bank_req_adapter_if #(.DataWidth(32), .ByteWidth(8), .AddrWidth(10)) b3 ();

    spatz_bank_req_adapter #(
        .DataWidth(32), .ByteWidth(8), .AddrWidth(10), .Latency(1), .RspDepth(2)
    ) u_l1 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (b1)
    );

    spatz_bank_req_adapter #(
        .DataWidth(32), .ByteWidth(8), .AddrWidth(10), .Latency(3), .RspDepth(4)
    ) u_l3 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (b3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers
    task automatic drv1(input logic v, input logic we, input logic [9:0] addr,
                        input logic [31:0] rdata, input logic gnt, input logic rr);
        b1.req_valid_i  = v;
        b1.req_we_i     = we;
        b1.req_addr_i   = addr;
        b1.req_wdata_i  = 32'h5555_0000 | {22'd0, addr};
        b1.req_be_i     = 4'hF;
        b1.bank_rdata_i = rdata;
        b1.bank_gnt_i   = gnt;
        b1.rsp_ready_i  = rr;
    endtask

    task automatic drv3(input logic v, input logic we, input logic [9:0] addr,
                        input logic [31:0] rdata, input logic gnt, input logic rr);
        b3.req_valid_i  = v;
        b3.req_we_i     = we;
        b3.req_addr_i   = addr;
        b3.req_wdata_i  = 32'h5555_0000 | {22'd0, addr};
        b3.req_be_i     = 4'hF;
        b3.bank_rdata_i = rdata;
        b3.bank_gnt_i   = gnt;
        b3.rsp_ready_i  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset holds off both ports and shows an idle, empty adapter
    task automatic test_reset();
        drv1(1'b1, 1'b0, 10'h001, 32'h0, 1'b1, 1'b1);
        drv3(1'b1, 1'b0, 10'h001, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", b1.req_ready_o); end
        n_cmp++; if (b1.bank_req_o !== 1'b0) begin n_err++; $display("FAIL rst_bank_req: got %b want 0", b1.bank_req_o); end
        n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", b1.rsp_valid_o); end
        n_cmp++; if (b1.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", b1.rsp_rdata_o); end
        n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", b1.idle_o); end
        n_cmp++; if (b3.bank_req_o !== 1'b0) begin n_err++; $display("FAIL rst_bank_req_l3: got %b want 0", b3.bank_req_o); end
        n_cmp++; if (b3.idle_o !== 1'b1) begin n_err++; $display("FAIL rst_idle_l3: got %b want 1", b3.idle_o); end
        tick();
        rst = 1'b0;
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1);
        drv3(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1);
        tick();
    endtask

    // Single read, response one cycle after the bank data
    task automatic test_single_read();
        drv1(1'b1, 1'b0, 10'h005, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", b1.req_ready_o); end
        n_cmp++; if (b1.bank_addr_o !== 10'h005) begin n_err++; $display("FAIL single_addr: got %h want 005", b1.bank_addr_o); end
        n_cmp++; if (b1.bank_we_o !== 1'b0) begin n_err++; $display("FAIL single_we: got %b want 0", b1.bank_we_o); end
        n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL single_idle_c0: got %b want 1", b1.idle_o); end
        tick();
        drv1(1'b0, 1'b0, 10'h0, 32'hDEADBEEF, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.idle_o !== 1'b0) begin n_err++; $display("FAIL single_idle_c1: got %b want 0", b1.idle_o); end
        n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_c1: got %b want 0", b1.rsp_valid_o); end
        tick();
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid_c2: got %b want 1", b1.rsp_valid_o); end
        n_cmp++; if (b1.rsp_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata_c2: got %h want deadbeef", b1.rsp_rdata_o); end
        n_cmp++; if (b1.idle_o !== 1'b0) begin n_err++; $display("FAIL single_idle_c2: got %b want 0", b1.idle_o); end
        tick();
        @(negedge clk);
        n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_c3: got %b want 0", b1.rsp_valid_o); end
        n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL single_idle_c3: got %b want 1", b1.idle_o); end
        tick();
    endtask

    // Four reads in consecutive cycles at full rate
    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp;
        for (int t = 0; t < 7; t++) begin
            rd = (t >= 1 && t <= 4) ? 32'hA0 + 32'(t - 1) : 32'h0;
            drv1(t < 4, 1'b0, 10'h010 + 10'(t), rd, 1'b1, 1'b1);
            @(negedge clk);
            if (t < 4) begin
                n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 1", t, b1.req_ready_o); end
            end
            if (t >= 2 && t <= 5) begin
                exp = 32'hA0 + 32'(t - 2);
                n_cmp++; if (b1.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want 1", t, b1.rsp_valid_o); end
                n_cmp++; if (b1.rsp_rdata_o !== exp) begin n_err++; $display("FAIL b2b_rdata c%0d: got %h want %h", t, b1.rsp_rdata_o, exp); end
            end
            if (t == 6) begin
                n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_valid_end: got %b want 0", b1.rsp_valid_o); end
                n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL b2b_idle_end: got %b want 1", b1.idle_o); end
            end
            tick();
        end
    endtask

    // Credit exhaustion with a stalled consumer, writes still pass, then drain
    task automatic test_credit_stall();
        // c0, c1: two reads accepted
        drv1(1'b1, 1'b0, 10'h030, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_ready_c0: got %b want 1", b1.req_ready_o); end
        tick();
        drv1(1'b1, 1'b0, 10'h030, 32'hB0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_ready_c1: got %b want 1", b1.req_ready_o); end
        tick();
        // c2, c3: out of credits
        for (int t = 2; t < 4; t++) begin
            drv1(1'b1, 1'b0, 10'h030, (t == 2) ? 32'hB1 : 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++; if (b1.bank_req_o !== 1'b0) begin n_err++; $display("FAIL stall_bank_req c%0d: got %b want 0", t, b1.bank_req_o); end
            n_cmp++; if (b1.req_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready c%0d: got %b want 0", t, b1.req_ready_o); end
            n_cmp++; if (b1.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid c%0d: got %b want 1", t, b1.rsp_valid_o); end
            n_cmp++; if (b1.rsp_rdata_o !== 32'hB0) begin n_err++; $display("FAIL stall_hold c%0d: got %h want b0", t, b1.rsp_rdata_o); end
            tick();
        end
        // c4: write needs no credit
        drv1(1'b1, 1'b1, 10'h020, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_wr_ready: got %b want 1", b1.req_ready_o); end
        n_cmp++; if (b1.bank_we_o !== 1'b1) begin n_err++; $display("FAIL stall_wr_we: got %b want 1", b1.bank_we_o); end
        n_cmp++; if (b1.bank_wdata_o !== 32'h5555_0020) begin n_err++; $display("FAIL stall_wr_wdata: got %h want 55550020", b1.bank_wdata_o); end
        tick();
        // c5: first pop and a new read in the same cycle
        drv1(1'b1, 1'b0, 10'h031, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.rsp_rdata_o !== 32'hB0) begin n_err++; $display("FAIL drain_rdata_c5: got %h want b0", b1.rsp_rdata_o); end
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_resume_c5: got %b want 1", b1.req_ready_o); end
        tick();
        drv1(1'b0, 1'b0, 10'h0, 32'hB2, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.rsp_rdata_o !== 32'hB1) begin n_err++; $display("FAIL drain_rdata_c6: got %h want b1", b1.rsp_rdata_o); end
        tick();
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid_c7: got %b want 1", b1.rsp_valid_o); end
        n_cmp++; if (b1.rsp_rdata_o !== 32'hB2) begin n_err++; $display("FAIL drain_rdata_c7: got %h want b2", b1.rsp_rdata_o); end
        tick();
        @(negedge clk);
        n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_valid_c8: got %b want 0", b1.rsp_valid_o); end
        n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL drain_idle_c8: got %b want 1", b1.idle_o); end
        tick();
    endtask

    // Denied grant leaves no trace; the later grant gives exactly one response
    task automatic test_gnt_denied();
        for (int t = 0; t < 3; t++) begin
            drv1(1'b1, 1'b0, 10'h040, 32'h0, 1'b0, 1'b1);
            @(negedge clk);
            n_cmp++; if (b1.req_ready_o !== 1'b0) begin n_err++; $display("FAIL gnt_ready c%0d: got %b want 0", t, b1.req_ready_o); end
            n_cmp++; if (b1.bank_req_o !== 1'b1) begin n_err++; $display("FAIL gnt_bank_req c%0d: got %b want 1", t, b1.bank_req_o); end
            n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL gnt_idle c%0d: got %b want 1", t, b1.idle_o); end
            tick();
        end
        drv1(1'b1, 1'b0, 10'h040, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL gnt_ready_c3: got %b want 1", b1.req_ready_o); end
        tick();
        drv1(1'b0, 1'b0, 10'h0, 32'hC4, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.idle_o !== 1'b0) begin n_err++; $display("FAIL gnt_idle_c4: got %b want 0", b1.idle_o); end
        tick();
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL gnt_valid_c5: got %b want 1", b1.rsp_valid_o); end
        n_cmp++; if (b1.rsp_rdata_o !== 32'hC4) begin n_err++; $display("FAIL gnt_rdata_c5: got %h want c4", b1.rsp_rdata_o); end
        tick();
        for (int t = 6; t < 8; t++) begin
            @(negedge clk);
            n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL gnt_extra_rsp c%0d: got %b want 0", t, b1.rsp_valid_o); end
            tick();
        end
    endtask

    // Reset while a read is in flight drops it for good
    task automatic test_mid_reset();
        drv1(1'b1, 1'b0, 10'h050, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.req_ready_o !== 1'b1) begin n_err++; $display("FAIL mrst_ready_c0: got %b want 1", b1.req_ready_o); end
        tick();
        rst = 1'b1;
        drv1(1'b0, 1'b0, 10'h0, 32'h1234, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid_c1: got %b want 0", b1.rsp_valid_o); end
        n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL mrst_idle_c1: got %b want 1", b1.idle_o); end
        tick();
        rst = 1'b0;
        for (int t = 2; t < 6; t++) begin
            drv1(1'b0, 1'b0, 10'h0, (t == 2) ? 32'h1234 : 32'h0, 1'b1, 1'b1);
            @(negedge clk);
            n_cmp++; if (b1.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid c%0d: got %b want 0", t, b1.rsp_valid_o); end
            n_cmp++; if (b1.idle_o !== 1'b1) begin n_err++; $display("FAIL mrst_idle c%0d: got %b want 1", t, b1.idle_o); end
            tick();
        end
    endtask

    // Latency 3, depth 4: eight reads with no stall, in-order responses
    task automatic test_latency3();
        logic [31:0] rd;
        logic [31:0] exp;
        for (int t = 0; t < 13; t++) begin
            rd = (t >= 3 && t <= 10) ? 32'hE0 + 32'(t - 3) : 32'h0;
            drv3(t < 8, 1'b0, 10'h060 + 10'(t), rd, 1'b1, 1'b1);
            @(negedge clk);
            if (t < 8) begin
                n_cmp++; if (b3.req_ready_o !== 1'b1) begin n_err++; $display("FAIL l3_ready c%0d: got %b want 1", t, b3.req_ready_o); end
            end
            if (t < 4) begin
                n_cmp++; if (b3.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL l3_early c%0d: got %b want 0", t, b3.rsp_valid_o); end
            end
            if (t >= 4 && t <= 11) begin
                exp = 32'hE0 + 32'(t - 4);
                n_cmp++; if (b3.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL l3_valid c%0d: got %b want 1", t, b3.rsp_valid_o); end
                n_cmp++; if (b3.rsp_rdata_o !== exp) begin n_err++; $display("FAIL l3_rdata c%0d: got %h want %h", t, b3.rsp_rdata_o, exp); end
            end
            if (t == 12) begin
                n_cmp++; if (b3.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL l3_valid_end: got %b want 0", b3.rsp_valid_o); end
                n_cmp++; if (b3.idle_o !== 1'b1) begin n_err++; $display("FAIL l3_idle_end: got %b want 1", b3.idle_o); end
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        drv3(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_credit_stall();
        test_gnt_denied();
        test_mid_reset();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
